// File: rtl/conv_accum_pool.sv
// Convolution partial-sum accumulator with bias, optional ReLU, optional 2x2 max-pool and
// output scaling/saturation. One beat per cycle; three register stages (sum, pool, output).
module conv_accum_pool #(
   parameter int unsigned CI      = 4,
   parameter int unsigned CO      = 12,
   parameter int unsigned I_SIZE  = 8,
   parameter int unsigned PSUM_BW = 28,
   parameter int unsigned B_BW    = 16,
   parameter int unsigned SUM_BW  = 32,
   parameter int unsigned O_BW    = 16,
   parameter int unsigned SHIFT   = 0
) (
   input  logic                    clk,
   input  logic                    global_rst_n,
   input  logic                    rst_processEnd,
   input  logic [CI*PSUM_BW-1:0]   i_psum,
   input  logic [CI-1:0]           i_psum_valid,
   input  logic [CO*B_BW-1:0]      i_bias,
   input  logic                    i_relu_en,
   input  logic                    i_pool_en,
   output logic signed [O_BW-1:0]  o_data,
   output logic                    o_valid,
   output logic                    o_ch_end,
   output logic                    o_allch_end,
   output logic                    o_align_err
);

   localparam int unsigned POS_W    = (I_SIZE > 2) ? $clog2(I_SIZE) : 1;
   localparam int unsigned CH_W     = (CO > 1) ? $clog2(CO) : 1;
   localparam int unsigned LB_DEPTH = I_SIZE / 2;
   localparam int unsigned LB_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(I_SIZE - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CO - 1);
   // Rounding constant: 2^(SHIFT-1) when SHIFT>0, else 0.
   localparam logic signed [SUM_BW:0] RND = ((SUM_BW + 1)'(1) << SHIFT) >> 1;
   localparam logic signed [SUM_BW:0] SAT_MAX = {{(SUM_BW - O_BW + 2){1'b0}}, {(O_BW - 1){1'b1}}};
   localparam logic signed [SUM_BW:0] SAT_MIN = {{(SUM_BW - O_BW + 2){1'b1}}, {(O_BW - 1){1'b0}}};

   // Frame position and mode state
   logic [POS_W-1:0] col_q, col_d, row_q, row_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic             done_q, done_d;
   logic             relu_q, relu_d, pool_q, pool_d;
   logic             align_err_q, align_err_d;

   // Stage 1: registered beat sum plus its position/modes
   logic                     s1_valid_q;
   logic signed [SUM_BW-1:0] s1_sum_q;
   logic [POS_W-1:0]         s1_col_q, s1_row_q;
   logic                     s1_ch_last_q, s1_relu_q, s1_pool_q;

   // Stage 2: pooled value
   logic                     s2_valid_q, s2_valid_d;
   logic signed [SUM_BW-1:0] s2_val_q, s2_val_d;
   logic                     s2_ce_q, s2_ce_d, s2_ae_q, s2_ae_d;
   logic signed [SUM_BW-1:0] hold_q, hold_d;

   // Output stage
   logic signed [O_BW-1:0]   data_q, data_d;
   logic                     valid_q, ch_end_q, allch_q;

   logic signed [SUM_BW-1:0] line_buf [LB_DEPTH];
   logic [LB_W-1:0]          lb_idx;
   logic                     lb_we;

   logic                     accept, misalign, first_beat, relu_cur, pool_cur;
   logic signed [SUM_BW-1:0] beat_sum, relu_val, pair_max, lb_rd;
   logic signed [SUM_BW:0]   rounded, shifted;

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_ch_end    = ch_end_q;
   assign o_allch_end = allch_q;
   assign o_align_err = align_err_q;

   // Beat acceptance; a finished frame is blocked from the last accepted beat onward
   always_comb begin
      accept     = (&i_psum_valid) && !allch_q && !done_q && !rst_processEnd;
      misalign   = (|i_psum_valid) && !(&i_psum_valid);
      first_beat = (col_q == '0) && (row_q == '0) && (ch_q == '0);
      relu_cur   = first_beat ? i_relu_en : relu_q;
      pool_cur   = first_beat ? i_pool_en : pool_q;
   end

   // Sign-extended sum of all channel psums plus the bias of the current output channel
   always_comb begin
      beat_sum = SUM_BW'(signed'(i_bias[ch_q*B_BW +: B_BW]));
      for (int k = 0; k < CI; k++) begin
         beat_sum = beat_sum + SUM_BW'(signed'(i_psum[k*PSUM_BW +: PSUM_BW]));
      end
   end

   // Raster counters (col, row, ch), mode latching and sticky alignment flag
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      ch_d        = ch_q;
      done_d      = done_q;
      relu_d      = relu_q;
      pool_d      = pool_q;
      align_err_d = align_err_q | misalign;
      if (accept) begin
         if (first_beat) begin
            relu_d = i_relu_en;
            pool_d = i_pool_en;
         end
         if (col_q == POS_LAST) begin
            col_d = '0;
            if (row_q == POS_LAST) begin
               row_d = '0;
               if (ch_q == CH_LAST) begin
                  ch_d   = '0;
                  done_d = 1'b1;
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // ReLU and 2x2 max-pool on the stage-1 value
   always_comb begin
      relu_val   = (s1_relu_q && s1_sum_q[SUM_BW-1]) ? '0 : s1_sum_q;
      pair_max   = (hold_q > relu_val) ? hold_q : relu_val;
      lb_idx     = LB_W'(s1_col_q >> 1);
      lb_rd      = line_buf[lb_idx];
      hold_d     = hold_q;
      lb_we      = 1'b0;
      s2_valid_d = 1'b0;
      s2_val_d   = s2_val_q;
      if (s1_valid_q) begin
         if (!s1_pool_q) begin
            s2_valid_d = 1'b1;
            s2_val_d   = relu_val;
         end else if (!s1_col_q[0]) begin
            hold_d = relu_val;
         end else if (!s1_row_q[0]) begin
            lb_we = 1'b1;
         end else begin
            s2_valid_d = 1'b1;
            s2_val_d   = (pair_max > lb_rd) ? pair_max : lb_rd;
         end
      end
      // Last output of a channel always comes from the bottom-right beat
      s2_ce_d = s2_valid_d && (s1_row_q == POS_LAST) && (s1_col_q == POS_LAST);
      s2_ae_d = s2_ce_d && s1_ch_last_q;
   end

   // Round, arithmetic shift and saturate to the output width
   always_comb begin
      rounded = $signed({s2_val_q[SUM_BW-1], s2_val_q}) + RND;
      shifted = rounded >>> SHIFT;
      data_d  = data_q;
      if (s2_valid_q) begin
         if (shifted > SAT_MAX) begin
            data_d = SAT_MAX[O_BW-1:0];
         end else if (shifted < SAT_MIN) begin
            data_d = SAT_MIN[O_BW-1:0];
         end else begin
            data_d = shifted[O_BW-1:0];
         end
      end
   end

   // Line buffer keeps the even-row pair maxima; contents need no reset
   always_ff @(posedge clk) begin
      if (lb_we) begin
         line_buf[lb_idx] <= pair_max;
      end
   end

   // State registers: async reset, synchronous frame clear, else advance
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         col_q <= '0;  row_q <= '0;  ch_q <= '0;  done_q <= 1'b0;
         relu_q <= 1'b0;  pool_q <= 1'b0;  align_err_q <= 1'b0;
         s1_valid_q <= 1'b0;  s1_sum_q <= '0;  s1_col_q <= '0;  s1_row_q <= '0;
         s1_ch_last_q <= 1'b0;  s1_relu_q <= 1'b0;  s1_pool_q <= 1'b0;
         s2_valid_q <= 1'b0;  s2_val_q <= '0;  s2_ce_q <= 1'b0;  s2_ae_q <= 1'b0;
         hold_q <= '0;
         data_q <= '0;  valid_q <= 1'b0;  ch_end_q <= 1'b0;  allch_q <= 1'b0;
      end else if (rst_processEnd) begin
         col_q <= '0;  row_q <= '0;  ch_q <= '0;  done_q <= 1'b0;
         relu_q <= 1'b0;  pool_q <= 1'b0;  align_err_q <= 1'b0;
         s1_valid_q <= 1'b0;  s1_sum_q <= '0;  s1_col_q <= '0;  s1_row_q <= '0;
         s1_ch_last_q <= 1'b0;  s1_relu_q <= 1'b0;  s1_pool_q <= 1'b0;
         s2_valid_q <= 1'b0;  s2_val_q <= '0;  s2_ce_q <= 1'b0;  s2_ae_q <= 1'b0;
         hold_q <= '0;
         data_q <= '0;  valid_q <= 1'b0;  ch_end_q <= 1'b0;  allch_q <= 1'b0;
      end else begin
         col_q <= col_d;  row_q <= row_d;  ch_q <= ch_d;  done_q <= done_d;
         relu_q <= relu_d;  pool_q <= pool_d;  align_err_q <= align_err_d;
         s1_valid_q <= accept;
         if (accept) begin
            s1_sum_q     <= beat_sum;
            s1_col_q     <= col_q;
            s1_row_q     <= row_q;
            s1_ch_last_q <= (ch_q == CH_LAST);
            s1_relu_q    <= relu_cur;
            s1_pool_q    <= pool_cur;
         end
         s2_valid_q <= s2_valid_d;  s2_val_q <= s2_val_d;
         s2_ce_q <= s2_ce_d;  s2_ae_q <= s2_ae_d;
         hold_q <= hold_d;
         data_q   <= data_d;
         valid_q  <= s2_valid_q;
         ch_end_q <= s2_ce_q;
         allch_q  <= allch_q | s2_ae_q;
      end
   end

endmodule

// File: tb/tb_conv_accum_pool.sv
// Scoreboard bench for conv_accum_pool: stimulus pushes expected outputs, a monitor pops them.
module tb_conv_accum_pool;

   logic                clk = 1'b0;
   logic                global_rst_n;
   logic                rst_processEnd;
   logic [111:0]        i_psum;
   logic [3:0]          i_psum_valid;
   logic [31:0]         i_bias;
   logic                i_relu_en;
   logic                i_pool_en;
   logic signed [15:0]  o_data;
   logic                o_valid;
   logic                o_ch_end;
   logic                o_allch_end;
   logic                o_align_err;

   typedef struct {
      int   d;
      logic ce;
      logic ae;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   conv_accum_pool #(
      .CI(4), .CO(2), .I_SIZE(4), .PSUM_BW(28), .B_BW(16), .SUM_BW(32), .O_BW(16), .SHIFT(0)
   ) dut (
      .clk            (clk),
      .global_rst_n   (global_rst_n),
      .rst_processEnd (rst_processEnd),
      .i_psum         (i_psum),
      .i_psum_valid   (i_psum_valid),
      .i_bias         (i_bias),
      .i_relu_en      (i_relu_en),
      .i_pool_en      (i_pool_en),
      .o_data         (o_data),
      .o_valid        (o_valid),
      .o_ch_end       (o_ch_end),
      .o_allch_end    (o_allch_end),
      .o_align_err    (o_align_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic push(input int d, input logic ce, input logic ae);
      exp_t e;
      e.d = d; e.ce = ce; e.ae = ae;
      exp_q.push_back(e);
   endtask

   task automatic beat(input int p0, input int p1, input int p2, input int p3);
      @(negedge clk);
      rst_processEnd = 1'b0;
      i_psum         = {28'(p3), 28'(p2), 28'(p1), 28'(p0)};
      i_psum_valid   = 4'hF;
   endtask

   task automatic drain();
      @(negedge clk);
      i_psum_valid = 4'h0;
      repeat (4) @(negedge clk);
   endtask

   task automatic frame_clear();
      @(negedge clk);
      rst_processEnd = 1'b1;
      i_psum_valid   = 4'h0;
      @(negedge clk);
      rst_processEnd = 1'b0;
   endtask

   // Monitor: every presented output must match the head of the expected queue
   always @(negedge clk) begin
      if (global_rst_n && o_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", int'(o_data), -99999);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", int'(o_data), e.d);
            check("out_ch_end", int'(o_ch_end), int'(e.ce));
            check("out_allch_end", int'(o_allch_end), int'(e.ae));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      global_rst_n   = 1'b0;
      rst_processEnd = 1'b0;
      i_psum         = '0;
      i_psum_valid   = 4'h0;
      i_bias         = '0;
      i_relu_en      = 1'b0;
      i_pool_en      = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_data", int'(o_data), 0);
      check("rst_valid", int'(o_valid), 0);
      check("rst_ch_end", int'(o_ch_end), 0);
      check("rst_allch_end", int'(o_allch_end), 0);
      check("rst_align_err", int'(o_align_err), 0);
      global_rst_n = 1'b1;

      // Pool on, all psums 1: eight outputs of 4, channel ends on the 4th and 8th
      i_pool_en = 1'b1;
      i_relu_en = 1'b0;
      for (int i = 0; i < 8; i++) push(4, (i == 3) || (i == 7), i == 7);
      for (int i = 0; i < 32; i++) beat(1, 1, 1, 1);
      drain();
      check("allch_after_frame", int'(o_allch_end), 1);
      beat(1, 1, 1, 1);  // blocked: must produce nothing
      drain();
      check("allch_held", int'(o_allch_end), 1);
      frame_clear();
      check("allch_cleared", int'(o_allch_end), 0);

      // Beat coinciding with frame clear is discarded; relu latched at frame start
      i_pool_en = 1'b0;
      i_relu_en = 1'b1;
      @(negedge clk);
      rst_processEnd = 1'b1;
      i_psum         = {28'(99), 28'(99), 28'(99), 28'(99)};
      i_psum_valid   = 4'hF;
      for (int i = 0; i < 4; i++) push(0, 1'b0, 1'b0);
      beat(-5, -5, -5, -5);
      @(posedge clk);
      #1 i_relu_en = 1'b0;
      for (int i = 0; i < 3; i++) beat(-5, -5, -5, -5);
      drain();
      frame_clear();
      for (int i = 0; i < 3; i++) push(-20, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) beat(-5, -5, -5, -5);
      drain();
      frame_clear();

      // Ramp pattern on channel 0, pool on; output channel 1 carries bias -3
      i_pool_en = 1'b1;
      i_relu_en = 1'b0;
      i_bias    = {16'hFFFD, 16'h0000};
      push(5, 1'b0, 1'b0);  push(7, 1'b0, 1'b0);
      push(13, 1'b0, 1'b0); push(15, 1'b1, 1'b0);
      push(2, 1'b0, 1'b0);  push(4, 1'b0, 1'b0);
      push(10, 1'b0, 1'b0); push(12, 1'b1, 1'b1);
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) beat(r * 4 + k, 0, 0, 0);
      drain();
      check("allch_ramp", int'(o_allch_end), 1);
      frame_clear();
      i_bias = '0;

      // Saturation both ways
      i_pool_en = 1'b0;
      push(32767, 1'b0, 1'b0);
      push(-32768, 1'b0, 1'b0);
      beat(20000, 20000, 20000, 20000);
      beat(-20000, -20000, -20000, -20000);
      drain();
      frame_clear();

      // Misaligned valid is dropped without advancing: channel end still on the 16th output
      for (int i = 0; i < 16; i++) push(4, i == 15, 1'b0);
      for (int i = 0; i < 16; i++) begin
         if (i == 3) begin
            @(negedge clk);
            i_psum       = {28'(7), 28'(7), 28'(7), 28'(7)};
            i_psum_valid = 4'b0111;
            @(posedge clk);
            #1 check("align_err_set", int'(o_align_err), 1);
         end
         beat(1, 1, 1, 1);
      end
      drain();
      check("align_err_sticky", int'(o_align_err), 1);
      frame_clear();
      check("align_err_cleared", int'(o_align_err), 0);

      // Asynchronous reset mid-frame, then a fresh pooled frame from position 0
      for (int i = 0; i < 5; i++) push(4 * (i + 1), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            @(negedge clk);
            i_psum_valid = 4'b0011;
         end
         beat(i + 1, i + 1, i + 1, i + 1);
      end
      drain();
      check("pre_reset_data", int'(o_data), 20);
      check("pre_reset_align", int'(o_align_err), 1);
      @(negedge clk);
      global_rst_n = 1'b0;
      #1;
      check("arst_data", int'(o_data), 0);
      check("arst_valid", int'(o_valid), 0);
      check("arst_ch_end", int'(o_ch_end), 0);
      check("arst_allch_end", int'(o_allch_end), 0);
      check("arst_align_err", int'(o_align_err), 0);
      @(negedge clk);
      global_rst_n = 1'b1;
      i_pool_en    = 1'b1;
      push(5, 1'b0, 1'b0);  push(7, 1'b0, 1'b0);
      push(13, 1'b0, 1'b0); push(15, 1'b1, 1'b0);
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) beat(r * 4 + k, 0, 0, 0);
      drain();

      check("all_expected_seen", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/conv_accum_pool.md
CONV_ACCUM_POOL -- requirements
Module: conv_accum_pool

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CI, 4, input channels summed per beat.
- CO, 12, output channels per frame.
- I_SIZE, 8, conv map side; must be even.
- PSUM_BW, 28, signed partial-sum width.
- B_BW, 16, signed bias width.
- SUM_BW, 32, internal accumulator width.
- O_BW, 16, signed output width.
- SHIFT, 0, output right-shift amount.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- global_rst_n, in, 1, reset; asynchronous, active-low.
- rst_processEnd, in, 1, synchronous frame clear.
- i_psum, in, CI*PSUM_BW, channel k at bits [k*PSUM_BW +: PSUM_BW], signed.
- i_psum_valid, in, CI, per-channel valid.
- i_bias, in, CO*B_BW, bias for output channel c at [c*B_BW +: B_BW], signed.
- i_relu_en, in, 1, ReLU enable.
- i_pool_en, in, 1, 2x2 max-pool enable.
- o_data, out, O_BW, signed result.
- o_valid, out, 1, o_data qualifier.
- o_ch_end, out, 1, one-cycle pulse on the last output of a channel.
- o_allch_end, out, 1, level; all CO channels done.
- o_align_err, out, 1, sticky channel-misalignment flag.

Function
REQ-003 A beat SHALL be accepted only when i_psum_valid is all ones, o_allch_end=0 and rst_processEnd=0.
REQ-004 When i_psum_valid is neither all zeros nor all ones, the beat SHALL be dropped with no counter advance, and o_align_err SHALL set until reset or rst_processEnd.
REQ-005 Stage 1, registered: sum = sign-extended sum of the CI psums + sign-extended i_bias[ch], in SUM_BW, two's-complement wrap.
REQ-006 If relu_en is latched 1, negative sums SHALL become 0.
REQ-007 Counters col, row (0..I_SIZE-1) and ch (0..CO-1) SHALL advance per accepted beat, raster order: col, then row, then ch.
REQ-008 i_relu_en and i_pool_en SHALL be latched on the first beat of each frame (ch=row=col=0) and held for the frame.
REQ-009 Pool on, even row: even col stores x in a hold register; odd col writes max(hold, x) to line buffer entry col/2 (depth I_SIZE/2).
REQ-010 Pool on, odd row: even col stores x in the hold register; odd col emits max(hold, x, linebuf[col/2]).
REQ-011 Pool off: every beat SHALL produce an output.
REQ-012 Output scaling: arithmetic right shift by SHIFT, adding 2^(SHIFT-1) first when SHIFT>0, then saturation to [-2^(O_BW-1), 2^(O_BW-1)-1].
REQ-013 Latency: o_valid SHALL assert exactly 2 cycles after the accepting edge of the beat completing an output; full throughput, one beat per cycle, no stalls.
REQ-014 o_ch_end SHALL pulse together with o_valid on the final output of each channel: (I_SIZE/2)^2 outputs with pool on, I_SIZE^2 with pool off.
REQ-015 o_allch_end SHALL rise with the o_ch_end of channel CO-1, stay high, and block further beats until rst_processEnd.
REQ-016 When rst_processEnd and a beat coincide, rst_processEnd SHALL win and the beat SHALL be discarded.

Reset
REQ-017 global_rst_n low SHALL asynchronously clear counters, pipeline valids, hold register, latched modes, o_data, o_valid, o_ch_end, o_allch_end and o_align_err to 0.
REQ-018 rst_processEnd SHALL synchronously clear the same state, except that line buffer contents need not be cleared.

Verification (CI=4, CO=2, I_SIZE=4, PSUM_BW=28, O_BW=16, SHIFT=0)
REQ-019 All psums 1, bias 0, pool on, 32 beats -> 4 outputs of 4 per channel; o_ch_end on outputs 4 and 8; o_allch_end high after output 8.
REQ-020 All psums -5, bias 0, pool off -> relu on gives 0; relu off gives -20.
REQ-021 Channel-0 psum = row*4+col, others 0, pool on -> outputs 5, 7, 13, 15.
REQ-022 All psums 20000 -> 32767; all psums -20000 with relu off -> -32768.
REQ-023 i_psum_valid=4'b0111 for one cycle -> o_align_err=1, no output, col unchanged; rst_processEnd -> o_align_err=0.
REQ-024 global_rst_n pulsed low after 5 beats -> all outputs 0 immediately; the next frame starts at row 0, col 0, ch 0 with correct results.
